// File: rtl/sysctrl_pkg.sv
// rtl/sysctrl_pkg.sv - sysctrl command codes, status signature and host FSM states
package sysctrl_pkg;

    localparam logic [7:0] CMD_STATUS  = 8'h00;
    localparam logic [7:0] CMD_LEDS    = 8'h01;
    localparam logic [7:0] CMD_COLOR   = 8'h02;
    localparam logic [7:0] CMD_BUTTONS = 8'h03;
    localparam logic [7:0] CMD_CONFIG  = 8'h04;
    localparam logic [7:0] CMD_IRQ     = 8'h05;

    localparam logic [7:0] STATUS_SIG0 = 8'h5C;
    localparam logic [7:0] STATUS_SIG1 = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_GAP,
        ST_SEND_BYTE,
        ST_CAPTURE,
        ST_DONE
    } host_state_e;

    // Payload counts above four are treated as four.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > 3'd4) ? 3'd4 : len;
    endfunction

endpackage

// File: rtl/sysctrl_host_pacer.sv
// rtl/sysctrl_host_pacer.sv - saturating gap counter, ticks on the last idle cycle of a gap
module sysctrl_host_pacer #(
    parameter int GAP_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    // A zero gap would allow back-to-back strobes, so it is raised to one.
    localparam logic [7:0] GAP_EFF = (GAP_CYCLES < 1)   ? 8'd1 :
                                     (GAP_CYCLES > 255) ? 8'd255 : 8'(GAP_CYCLES);

    logic [7:0] count;

    // Count cycles spent in the gap; restart from zero whenever the gap is left.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= 8'd0;
        end else if (count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign tick = run && (count == GAP_EFF - 8'd1);

endmodule

// File: rtl/sysctrl_host.sv
// rtl/sysctrl_host.sv - sysctrl byte-protocol initiator; SYSCTRL_HOST_AUTO_IRQ_POLL_EN adds interrupt polling
module sysctrl_host
    import sysctrl_pkg::*;
#(
    parameter int GAP_CYCLES   = 3,
    parameter int POLL_HOLDOFF = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        data_in_strobe,
    output logic        data_in_start,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    input  logic        int_out_n,
    output logic        irq_valid,
    output logic [7:0]  irq_status
);

    host_state_e state;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic [31:0] data_q;
    logic        gap_tick;
    logic        is_poll;
    logic [4:0]  bit_idx;
    logic        last_byte;

    assign bit_idx   = {idx_q[1:0], 3'b000};
    assign last_byte = (idx_q + 3'd1) == len_q;

    sysctrl_host_pacer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_pacer (
        .clk   (clk),
        .reset (reset),
        .run   (state == ST_GAP),
        .tick  (gap_tick)
    );

`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
    logic [31:0] holdoff_q;
    logic        poll_due;

    assign poll_due = !int_out_n && (holdoff_q == 32'd0);

    // Holdoff between polls: starts expired, reloads when a poll frame finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            holdoff_q <= 32'd0;
        end else if (state == ST_DONE && is_poll) begin
            holdoff_q <= 32'(POLL_HOLDOFF);
        end else if (holdoff_q != 32'd0) begin
            holdoff_q <= holdoff_q - 32'd1;
        end
    end
`else
    logic unused_poll_inputs;
    assign unused_poll_inputs = int_out_n ^ POLL_HOLDOFF[0];
    assign is_poll    = 1'b0;
    assign irq_valid  = 1'b0;
    assign irq_status = 8'd0;
`endif

    // Frame sequencer: outputs are registered on entry to the state that shows them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= 32'd0;
            busy           <= 1'b0;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            data_in        <= 8'd0;
            len_q          <= 3'd0;
            idx_q          <= 3'd0;
            data_q         <= 32'd0;
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
            is_poll        <= 1'b0;
            irq_valid      <= 1'b0;
            irq_status     <= 8'd0;
`endif
        end else begin
            rsp_valid      <= 1'b0;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
            irq_valid      <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        len_q          <= clamp_len(req_len);
                        data_q         <= req_data;
                        idx_q          <= 3'd0;
                        rsp_data       <= 32'd0;
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        data_in_strobe <= 1'b1;
                        data_in_start  <= 1'b1;
                        data_in        <= req_cmd;
                        state          <= ST_SEND_CMD;
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
                        is_poll        <= 1'b0;
                    end else if (poll_due) begin
                        len_q          <= 3'd1;
                        data_q         <= 32'd0;
                        idx_q          <= 3'd0;
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        data_in_strobe <= 1'b1;
                        data_in_start  <= 1'b1;
                        data_in        <= CMD_IRQ;
                        state          <= ST_SEND_CMD;
                        is_poll        <= 1'b1;
`endif
                    end
                end
                ST_SEND_CMD: begin
                    if (len_q == 3'd0) begin
                        rsp_valid <= !is_poll;
                        state     <= ST_DONE;
                    end else begin
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_tick) begin
                        data_in_strobe <= 1'b1;
                        data_in        <= data_q[bit_idx +: 8];
                        state          <= ST_SEND_BYTE;
                    end
                end
                ST_SEND_BYTE: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
                    if (is_poll) begin
                        if (last_byte) begin
                            irq_valid  <= 1'b1;
                            irq_status <= data_out;
                        end
                    end else
`endif
                    rsp_data[bit_idx +: 8] <= data_out;
                    idx_q <= idx_q + 3'd1;
                    if (last_byte) begin
                        rsp_valid <= !is_poll;
                        state     <= ST_DONE;
                    end else begin
                        state     <= ST_GAP;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
                    is_poll   <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysctrl_host.sv
// tb/tb_sysctrl_host.sv - randomized self-checking bench for sysctrl_host with a behavioural responder
module tb_sysctrl_host;
    import sysctrl_pkg::*;

    localparam int GAP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [2:0]  req_len;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        data_in_strobe;
    logic        data_in_start;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        int_out_n;
    logic        irq_valid;
    logic [7:0]  irq_status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sysctrl_host #(.GAP_CYCLES(GAP), .POLL_HOLDOFF(1024)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_len(req_len), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
        .data_out(data_out), .int_out_n(int_out_n),
        .irq_valid(irq_valid), .irq_status(irq_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder reply rule: status signature for CMD_STATUS, pending flag for CMD_IRQ, scrambled echo otherwise.
    function automatic logic [7:0] reply_byte(input logic [7:0] cmd, input int idx, input logic [7:0] b, input logic pend);
        if (cmd == CMD_STATUS) begin
            case (idx)
                0: return STATUS_SIG0;
                1: return STATUS_SIG1;
                2: return 8'h03;
                default: return 8'h00;
            endcase
        end
        if (cmd == CMD_IRQ) return {7'd0, pend};
        return b ^ 8'hA5 ^ 8'(idx);
    endfunction

    logic [7:0] r_cmd, r_key, scanlines;
    int         r_idx;
    logic       irq_pending;
    logic       raise_irq;

    assign int_out_n = !irq_pending;

    // Behavioural sysctrl responder: reply appears the cycle after each payload strobe.
    always @(posedge clk) begin
        if (reset) begin
            r_cmd <= 8'd0; r_key <= 8'd0; r_idx <= 0; data_out <= 8'd0;
            scanlines <= 8'd0; irq_pending <= 1'b0;
        end else begin
            if (raise_irq) irq_pending <= 1'b1;
            if (data_in_strobe) begin
                if (data_in_start) begin
                    r_cmd <= data_in;
                    r_idx <= 0;
                end else begin
                    data_out <= reply_byte(r_cmd, r_idx, data_in, irq_pending);
                    if (r_cmd == CMD_IRQ && data_in[0]) irq_pending <= 1'b0;
                    if (r_cmd == CMD_CONFIG && r_idx == 0) r_key <= data_in;
                    if (r_cmd == CMD_CONFIG && r_idx == 1 && r_key == 8'h53) scanlines <= data_in;
                    r_idx <= r_idx + 1;
                end
            end
        end
    end

    int         str_cyc[$];
    logic [7:0] str_dat[$];
    bit         str_st[$];

    // Strobe monitor: logs every strobe and checks framing rules throughout the run.
    initial begin
        logic prev_strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && (data_in_strobe || data_in_start)) begin
                n_checks++;
                if (data_in_start && !data_in_strobe) begin
                    n_fail++; $display("FAIL start_without_strobe at cycle %0d", cyc);
                end else if (data_in_strobe && prev_strobe) begin
                    n_fail++; $display("FAIL adjacent_strobes at cycle %0d", cyc);
                end
                if (data_in_strobe) begin
                    str_cyc.push_back(cyc); str_dat.push_back(data_in); str_st.push_back(data_in_start);
                end
            end
            prev_strobe = data_in_strobe;
        end
    end

    task automatic wait_ready(input string tag);
        int w = 0;
        while (req_ready !== 1'b1 && w < 500) begin @(negedge clk); w++; end
        if (req_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", tag, req_ready);
        end
    endtask

    task automatic wait_rsp(output bit got);
        int w = 0;
        got = 0;
        while (w < 2000) begin
            if (rsp_valid === 1'b1) begin got = 1; break; end
            @(negedge clk); w++;
        end
    endtask

    task automatic check_strobes(input int acc, input logic [7:0] cmd, input int l, input logic [31:0] data, input string tag);
        n_checks++;
        if (str_cyc.size() != l + 1) begin
            n_fail++; $display("FAIL %s strobe_count: got %0d required %0d", tag, str_cyc.size(), l + 1);
        end else begin
            for (int k = 0; k <= l; k++) begin
                int         ec;
                logic [7:0] ed;
                ec = (k == 0) ? acc + 1 : acc + 1 + (GAP + 1) + (k - 1) * (GAP + 2);
                ed = (k == 0) ? cmd : data[8*(k-1) +: 8];
                n_checks++;
                if (str_cyc[k] != ec || str_dat[k] !== ed || str_st[k] != (k == 0)) begin
                    n_fail++;
                    $display("FAIL %s strobe%0d: cycle %0d data %h start %0d required cycle %0d data %h start %0d",
                             tag, k, str_cyc[k] - acc, str_dat[k], str_st[k], ec - acc, ed, k == 0);
                end
            end
        end
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [2:0] len, input logic [31:0] data, input string tag);
        int          l, acc, lat;
        logic [31:0] exp;
        bit          got;
        l = (len > 3'd4) ? 4 : int'(len);
        exp = '0;
        for (int i = 0; i < l; i++) exp[8*i +: 8] = reply_byte(cmd, i, data[8*i +: 8], irq_pending);
        wait_ready(tag);
        str_cyc.delete(); str_dat.delete(); str_st.delete();
        req_valid = 1'b1; req_cmd = cmd; req_len = len; req_data = data; acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(got);
        lat = cyc - acc;
        n_checks++;
        if (!got || lat != 2 + l * (GAP + 2)) begin
            n_fail++; $display("FAIL %s latency: got %0d (seen %0d) required %0d", tag, lat, got, 2 + l * (GAP + 2));
        end
        n_checks++;
        if (rsp_data !== exp) begin
            n_fail++; $display("FAIL %s rsp_data: got %h required %h", tag, rsp_data, exp);
        end
        check_strobes(acc, cmd, l, data, tag);
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== exp || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: rsp_valid=%b rsp_data=%h req_ready=%b busy=%b required 0 %h 1 0",
                     tag, rsp_valid, rsp_data, req_ready, busy, exp);
        end
    endtask

    task automatic test_reset();
        logic [53:0] got;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got = {req_ready, busy, rsp_valid, data_in_strobe, data_in_start, data_in, rsp_data, irq_valid, irq_status};
        n_checks++;
        if (got !== {1'b1, 53'd0}) begin
            n_fail++; $display("FAIL reset_values: got %h required %h", got, {1'b1, 53'd0});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_status_read();
        do_frame(CMD_STATUS, 3'd3, $urandom, "status_read");
        n_checks++;
        if (rsp_data !== 32'h0003425C) begin
            n_fail++; $display("FAIL status_signature: got %h required 0003425c", rsp_data);
        end
    endtask

    task automatic test_config_write();
        do_frame(CMD_CONFIG, 3'd2, 32'h0000_0153, "config_write");
        n_checks++;
        if (scanlines !== 8'd1) begin
            n_fail++; $display("FAIL config_scanlines: got %0d required 1", scanlines);
        end
    endtask

    task automatic test_zero_len();
        do_frame(CMD_LEDS, 3'd0, $urandom, "zero_len");
    endtask

    task automatic test_random();
        logic [7:0] cmds [5];
        cmds = '{CMD_STATUS, CMD_LEDS, CMD_COLOR, CMD_BUTTONS, CMD_CONFIG};
        for (int n = 0; n < 12; n++) begin
            do_frame(cmds[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), $urandom, $sformatf("random%0d", n));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, e1, e2;
        int          acc1, acc2, rsp1c, w;
        bit          got1, got2;
        d1 = $urandom; d2 = $urandom;
        e1 = {16'd0, reply_byte(CMD_COLOR, 1, d1[15:8], 1'b0), reply_byte(CMD_COLOR, 0, d1[7:0], 1'b0)};
        e2 = {24'd0, reply_byte(CMD_BUTTONS, 0, d2[7:0], 1'b0)};
        wait_ready("b2b");
        req_valid = 1'b1; req_cmd = CMD_COLOR; req_len = 3'd2; req_data = d1; acc1 = cyc;
        @(negedge clk);
        req_cmd = CMD_BUTTONS; req_len = 3'd1; req_data = d2;
        w = 0; got1 = 0; acc2 = -1; rsp1c = -1;
        while (w < 200) begin
            if (rsp_valid === 1'b1) begin
                got1 = 1; rsp1c = cyc;
                n_checks++;
                if (rsp_data !== e1) begin
                    n_fail++; $display("FAIL b2b_rsp1_data: got %h required %h", rsp_data, e1);
                end
            end
            if (req_ready === 1'b1) begin acc2 = cyc; break; end
            @(negedge clk); w++;
        end
        n_checks++;
        if (!got1 || rsp1c != acc1 + 2 + 2 * (GAP + 2)) begin
            n_fail++; $display("FAIL b2b_rsp1_latency: got %0d required %0d", rsp1c - acc1, 2 + 2 * (GAP + 2));
        end
        n_checks++;
        if (acc2 != acc1 + 3 + 2 * (GAP + 2)) begin
            n_fail++; $display("FAIL b2b_second_accept: got %0d required %0d", acc2 - acc1, 3 + 2 * (GAP + 2));
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(got2);
        n_checks++;
        if (!got2 || cyc - acc2 != 2 + (GAP + 2) || rsp_data !== e2) begin
            n_fail++; $display("FAIL b2b_rsp2: latency %0d data %h required %0d %h", cyc - acc2, rsp_data, 2 + (GAP + 2), e2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int          acc, w;
        bit          seen;
        logic [53:0] got;
        wait_ready("mid_reset");
        req_valid = 1'b1; req_cmd = CMD_STATUS; req_len = 3'd3; req_data = $urandom; acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (cyc < acc + 8 && w < 50) begin @(negedge clk); w++; end
        n_checks++;
        if (busy !== 1'b1 || data_in_strobe !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_in_gap: busy=%b strobe=%b required 1 0", busy, data_in_strobe);
        end
        reset = 1'b1;
        @(negedge clk);
        got = {req_ready, busy, rsp_valid, data_in_strobe, data_in_start, data_in, rsp_data, irq_valid, irq_status};
        n_checks++;
        if (got !== {1'b1, 53'd0}) begin
            n_fail++; $display("FAIL mid_reset_values: got %h required %h", got, {1'b1, 53'd0});
        end
        reset = 1'b0;
        seen = 0;
        repeat (30) begin @(negedge clk); if (rsp_valid === 1'b1) seen = 1; end
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_no_rsp: rsp_seen=%0d busy=%b required 0 0", seen, busy);
        end
        test_status_read();
    endtask

    task automatic test_irq();
        int w;
        bit seen;
        raise_irq = 1'b1;
        @(negedge clk);
        raise_irq = 1'b0;
`ifdef SYSCTRL_HOST_AUTO_IRQ_POLL_EN
        w = 0; seen = 0;
        while (irq_valid !== 1'b1 && w < 100) begin
            if (rsp_valid === 1'b1) seen = 1;
            @(negedge clk); w++;
        end
        n_checks++;
        if (irq_valid !== 1'b1 || irq_status[0] !== 1'b1 || seen) begin
            n_fail++; $display("FAIL irq_poll: irq_valid=%b status=%h rsp_seen=%0d required 1 x1 0", irq_valid, irq_status, seen);
        end
        do_frame(CMD_IRQ, 3'd1, 32'h0000_0001, "irq_ack");
        n_checks++;
        if (int_out_n !== 1'b1) begin
            n_fail++; $display("FAIL irq_ack_clear: int_out_n=%b required 1", int_out_n);
        end
        seen = 0;
        repeat (100) begin @(negedge clk); if (irq_valid === 1'b1 || busy === 1'b1) seen = 1; end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL irq_no_repoll: activity=%0d required 0", seen);
        end
`else
        w = 0; seen = 0;
        while (w < 50) begin
            if (irq_valid !== 1'b0 || irq_status !== 8'd0 || busy !== 1'b0) seen = 1;
            @(negedge clk); w++;
        end
        n_checks++;
        if (seen || int_out_n !== 1'b0) begin
            n_fail++; $display("FAIL irq_ignored: activity=%0d int_out_n=%b required 0 0", seen, int_out_n);
        end
`endif
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_cmd = 8'd0; req_len = 3'd0; req_data = 32'd0; raise_irq = 1'b0;
        @(negedge clk);
        test_reset();
        test_status_read();
        test_config_write();
        test_zero_len();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_irq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
